// File: rtl/stopwatch_bcd_core_if.sv
// rtl/stopwatch_bcd_core_if.sv - button inputs and display outputs of the BCD stopwatch
//
// master : drives the raw buttons and reads the display (board/testbench side)
// slave  : the stopwatch core
//   btn_start, btn_lap, btn_clr : raw active-high push-buttons, asynchronous to clk
//   bcd_out[15:0]               : packed BCD time {m10, m1, s10, s1}
//   running                     : high while counting
//   lap_hold                    : high while bcd_out is frozen
//   ovf                         : sticky 99:59 -> 00:00 rollover flag
interface stopwatch_bcd_core_if;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clr;
  logic [15:0] bcd_out;
  logic        running;
  logic        lap_hold;
  logic        ovf;

  modport master (
    output btn_start, btn_lap, btn_clr,
    input  bcd_out, running, lap_hold, ovf
  );

  modport slave (
    input  btn_start, btn_lap, btn_clr,
    output bcd_out, running, lap_hold, ovf
  );
endinterface

// File: rtl/stopwatch_bcd_core.sv
// rtl/stopwatch_bcd_core.sv - debounced MM:SS stopwatch producing packed BCD for the digit scanner
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   sw    : slave side of stopwatch_bcd_core_if (raw buttons in, bcd_out/running/lap_hold/ovf out)
// Parameters:
//   TICK_DIV   : clk cycles per counted second
//   DEB_CYCLES : consecutive stable cycles before a button level change is accepted
module stopwatch_bcd_core #(
  parameter int TICK_DIV   = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stopwatch_bcd_core_if.slave   sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Button index: 0 = start, 1 = lap, 2 = clear.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    deb_q;
  logic [2:0]    deb_prev_q;
  logic [2:0]    armed_q;
  logic [1:0]    vld_q;
  logic [DW-1:0] deb_cnt_q [3];
  logic [2:0]    pulse;

  assign btn_raw = {sw.btn_clr, sw.btn_lap, sw.btn_start};

  // armed_q blocks the press pulse until the synchronized button has been seen low
  // after reset, so a button held through reset needs a release and a new press.
  // vld_q waits out the two synchronizer stages, whose reset zeros are not real samples.
  assign pulse = deb_q & ~deb_prev_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      armed_q    <= '0;
      vld_q      <= '0;
      for (int b = 0; b < 3; b++) begin
        deb_cnt_q[b] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      vld_q      <= {vld_q[0], 1'b1};
      for (int b = 0; b < 3; b++) begin
        if (vld_q[1] && !sync2_q[b]) begin
          armed_q[b] <= 1'b1;
        end
        if (sync2_q[b] == deb_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_cnt_q[b] == DEB_LAST) begin
          deb_q[b]     <= sync2_q[b];
          deb_cnt_q[b] <= '0;
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  logic p_start;
  logic p_lap;
  logic p_clr;
  assign p_start = pulse[0];
  assign p_lap   = pulse[1];
  assign p_clr   = pulse[2];

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   tm_q;
  logic [15:0]   bcd_q;
  logic          running_q;
  logic          lap_q;
  logic          ovf_q;

  logic [15:0]   tm_inc;
  logic          tm_wrap;
  logic          tick;
  logic          clr;
  logic [15:0]   tm_d;

  // One-second BCD increment with per-digit carry; 99:59 wraps to 00:00.
  always_comb begin
    tm_inc  = tm_q;
    tm_wrap = 1'b0;
    if (tm_q[3:0] != 4'd9) begin
      tm_inc[3:0] = tm_q[3:0] + 4'd1;
    end else begin
      tm_inc[3:0] = 4'd0;
      if (tm_q[7:4] != 4'd5) begin
        tm_inc[7:4] = tm_q[7:4] + 4'd1;
      end else begin
        tm_inc[7:4] = 4'd0;
        if (tm_q[11:8] != 4'd9) begin
          tm_inc[11:8] = tm_q[11:8] + 4'd1;
        end else begin
          tm_inc[11:8] = 4'd0;
          if (tm_q[15:12] != 4'd9) begin
            tm_inc[15:12] = tm_q[15:12] + 4'd1;
          end else begin
            tm_inc[15:12] = 4'd0;
            tm_wrap       = 1'b1;
          end
        end
      end
    end
  end

  // A start pulse in RUN pauses on that edge, so no tick is taken on it.
  always_comb begin
    tick = (state_q == ST_RUN) && !p_start && (presc_q == PRESC_LAST);
    clr  = (state_q == ST_PAUSE) && p_clr;
    tm_d = clr ? 16'h0000 : (tick ? tm_inc : tm_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tm_q      <= '0;
      bcd_q     <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      tm_q <= tm_d;
      // The display keeps tracking on the edge lap_hold rises (capturing that
      // value) and resumes one edge after it falls.
      if (clr) begin
        bcd_q <= '0;
      end else if (!lap_q) begin
        bcd_q <= tm_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (p_start) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
            presc_q   <= '0;
          end
        end
        ST_RUN: begin
          if (p_start) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end else if (tick) begin
            presc_q <= '0;
            if (tm_wrap) begin
              ovf_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
          if (p_lap) begin
            lap_q <= !lap_q;
          end
        end
        ST_PAUSE: begin
          if (p_clr) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            lap_q   <= 1'b0;
            ovf_q   <= 1'b0;
          end else begin
            if (p_start) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
            if (p_lap) begin
              lap_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign sw.bcd_out  = bcd_q;
  assign sw.running  = running_q;
  assign sw.lap_hold = lap_q;
  assign sw.ovf      = ovf_q;

endmodule
